xor_parity_arbiter: RTL and testbench

Round-robin controller that shares one 3-input XOR parity stage among three requesters. Each requester submits a DATA_W-bit word and an odd/even mode. The block grants one requester at a time and folds the word two bits per cycle through the shared XOR stage (acc ^ b0 ^ b1). It then reports the parity result tagged with the requester ID. It sits between the gate-level XOR datapath and any client logic that needs word parity without instantiating its own reduction tree.

---
 rtl/xor_parity_arbiter_if.sv | 26 ++
 rtl/xor_parity_arbiter.sv | 126 ++++++++++++
 tb/tb_xor_parity_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/xor_parity_arbiter_if.sv
// Request/grant/result bundle between three parity requesters and the shared
// XOR parity arbiter.
interface xor_parity_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [2:0]        req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [2:0]        odd;
  logic [2:0]        gnt;
  logic              busy;
  logic              done;
  logic [1:0]        done_id;
  logic              parity;

  modport master (
    output req, data0, data1, data2, odd,
    input  gnt, busy, done, done_id, parity
  );

  modport slave (
    input  req, data0, data1, data2, odd,
    output gnt, busy, done, done_id, parity
  );
endinterface

// File: rtl/xor_parity_arbiter.sv
// Round-robin arbiter sharing one 3-input XOR stage among three requesters;
// folds the granted word two bits per cycle and reports tagged parity.
module xor_parity_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xor_parity_arbiter_if.slave  bus
);
  localparam int HALF  = DATA_W / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            r_state;
  logic [1:0]        r_last;
  logic [1:0]        r_win;
  logic [DATA_W-1:0] r_sh;
  logic              r_mode;
  logic              r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_gnt;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_done_id;
  logic              r_parity;

  logic [1:0]        w_win;
  logic [1:0]        w_idx;
  logic              w_found;
  logic [DATA_W-1:0] w_data;
  logic              w_mode;
  logic              w_acc_nxt;

  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_idx = 2'((32'(r_last) + 32'd1 + k) % 32'd3);
      if (!w_found && bus.req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_data = bus.data2;
    w_mode = bus.odd[2];
    case (r_win)
      2'd0: begin
        w_data = bus.data0;
        w_mode = bus.odd[0];
      end
      2'd1: begin
        w_data = bus.data1;
        w_mode = bus.odd[1];
      end
      default: ;
    endcase
  end

  assign w_acc_nxt = r_acc ^ r_sh[0] ^ r_sh[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= 2'd2;
      r_win     <= '0;
      r_sh      <= '0;
      r_mode    <= 1'b0;
      r_acc     <= 1'b0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_parity  <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_win   <= w_win;
            r_last  <= w_win;
            r_gnt   <= 3'b001 << w_win;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_sh    <= w_data;
          r_mode  <= w_mode;
          r_acc   <= 1'b0;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_acc <= w_acc_nxt;
          r_sh  <= r_sh >> 2;
          r_cnt <= r_cnt + 1'b1;
          // Result is formed from the final fold so it is registered for the DONE cycle.
          if (r_cnt == CNT_W'(HALF - 1)) begin
            r_done    <= 1'b1;
            r_parity  <= w_acc_nxt ^ r_mode;
            r_done_id <= r_win;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.parity  = r_parity;
endmodule

// File: tb/tb_xor_parity_arbiter.sv
// Scoreboard bench for xor_parity_arbiter: directed requests push expected
// grants/results; a monitor pops and compares on gnt and done.
module tb_xor_parity_arbiter;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xor_parity_arbiter_if #(.DATA_W(DATA_W)) bus ();

  xor_parity_arbiter #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] gnt;
    int         spacing;
  } gexp_t;

  typedef struct {
    logic [1:0] id;
    logic       par;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_gnt_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_g(input logic [2:0] g, input int sp);
    gexp_t e;
    e.gnt = g;
    e.spacing = sp;
    gq.push_back(e);
  endtask

  task automatic push_r(input logic [1:0] id, input logic par);
    rexp_t e;
    e.id = id;
    e.par = par;
    rq.push_back(e);
  endtask

  // Monitor
  initial begin
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != 3'b000) begin
        if (gq.size() == 0) check("gnt_unexpected", 32'(bus.gnt), 32'd0);
        else begin
          g = gq.pop_front();
          check("gnt_value", 32'(bus.gnt), 32'(g.gnt));
          if (g.spacing > 0) check("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'(g.spacing));
        end
        last_gnt_cyc = cyc;
      end
      if (bus.done) begin
        if (rq.size() == 0) check("done_unexpected", 32'(bus.done), 32'd0);
        else begin
          r = rq.pop_front();
          check("done_id", 32'(bus.done_id), 32'(r.id));
          check("parity", 32'(bus.parity), 32'(r.par));
          check("done_latency", 32'(cyc - last_gnt_cyc), 32'd5);
        end
      end
    end
  end

  task automatic run_until_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.gnt != 3'b000) bus.req = bus.req & ~bus.gnt;
      if (bus.req == 3'b000 && !bus.busy && rq.size() == 0 && gq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_gnt();
    bit ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.gnt != 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int ng;
    bit ok;
    rst_n     = 1'b0;
    bus.req   = 3'b000;
    bus.odd   = 3'b000;
    bus.data0 = 8'h01;
    bus.data1 = 8'h03;
    bus.data2 = 8'hFF;
    bus.req   = 3'b111;
    repeat (2) @(negedge clk);
    check("rst_gnt",     32'(bus.gnt),     32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_done_id", 32'(bus.done_id), 32'd0);
    check("rst_parity",  32'(bus.parity),  32'd0);

    // All three held from reset: order 0,1,2,0
    push_g(3'b001, 0); push_g(3'b010, 7); push_g(3'b100, 7); push_g(3'b001, 7);
    push_r(2'd0, 1'b1); push_r(2'd1, 1'b0); push_r(2'd2, 1'b0); push_r(2'd0, 1'b1);
    rst_n = 1'b1;
    ng = 0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.gnt != 3'b000) ng++;
      if (ng == 4) begin
        bus.req = 3'b000;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("held_gnt_timeout", 32'd0, 32'd1);
    run_until_idle();

    // Single request, even mode, A5 has four ones
    bus.data0 = 8'hA5; bus.odd = 3'b000; bus.req = 3'b001;
    push_g(3'b001, 0); push_r(2'd0, 1'b0);
    run_until_idle();

    // Odd mode on requester 1, then even mode
    bus.data1 = 8'h07; bus.odd = 3'b010; bus.req = 3'b010;
    push_g(3'b010, 0); push_r(2'd1, 1'b0);
    run_until_idle();
    bus.odd = 3'b000; bus.req = 3'b010;
    push_g(3'b010, 0); push_r(2'd1, 1'b1);
    run_until_idle();

    // Fairness: serve 2, then 0 and 2 together -> 0 first
    bus.data2 = 8'hFF; bus.req = 3'b100;
    push_g(3'b100, 0); push_r(2'd2, 1'b0);
    run_until_idle();
    bus.data0 = 8'h01; bus.data2 = 8'h03; bus.req = 3'b101;
    push_g(3'b001, 0); push_g(3'b100, 7);
    push_r(2'd0, 1'b1); push_r(2'd2, 1'b0);
    run_until_idle();

    // Data changed after the grant cycle has no effect
    bus.data0 = 8'h01; bus.req = 3'b001;
    push_g(3'b001, 0); push_r(2'd0, 1'b1);
    wait_gnt();
    bus.req = 3'b000;
    @(negedge clk);
    bus.data0 = 8'h00;
    run_until_idle();

    // Reset during SHIFT aborts without done
    bus.data0 = 8'hA5; bus.req = 3'b001;
    push_g(3'b001, 0);
    wait_gnt();
    bus.req = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_parity", 32'(bus.parity), 32'd0);
    check("midrst_done",   32'(bus.done),   32'd0);
    check("midrst_gnt",    32'(bus.gnt),    32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.data2 = 8'h0B; bus.odd = 3'b000; bus.req = 3'b100;
    push_g(3'b100, 0); push_r(2'd2, 1'b1);
    run_until_idle();

    repeat (5) @(negedge clk);
    check("queues_empty", 32'(gq.size() + rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
